// File: rtl/lns_pkg.sv
// -----------------------------------------------------------------------------
// lns_pkg
// Shared definitions for the 12-bit LNS datapath (multiply stage and adder).
//   LNS word: [11] sign (1 = negative), [10:0] two's-complement log2 magnitude
//   in Q4.7 (128 = 1.0). A log field of 11'h400 encodes zero.
// -----------------------------------------------------------------------------
package lns_pkg;

   localparam int LNS_W  = 12;
   localparam int LOG_W  = 11;
   localparam int FRAC_W = 7;

   typedef struct packed {
      logic             sgn;
      logic [LOG_W-1:0] log;
   } lns_t;

   localparam lns_t LNS_ZERO = 12'h400;
   localparam int   LOG_MAX  = 1023;
   localparam int   LOG_MIN  = -1024;

   // True when the log field carries the zero code, whatever the sign bit.
   function automatic logic lns_is_zero(input lns_t v);
      return (v.log == 11'h400);
   endfunction

endpackage : lns_pkg

// File: rtl/lns_sat_pack.sv
// -----------------------------------------------------------------------------
// lns_sat_pack
// Combinational pack/saturate of a log-domain product.
//   i_sgn     : product sign
//   i_sum     : 12-bit signed sum of the two operand log fields
//   i_zero    : at least one operand was zero
//   o_x       : packed LNS product
//   o_sat_evt : product overflowed or underflowed the log range
// -----------------------------------------------------------------------------
module lns_sat_pack
   import lns_pkg::*;
(
   input  logic                    i_sgn,
   input  logic signed [LNS_W-1:0] i_sum,
   input  logic                    i_zero,
   output lns_t                    o_x,
   output logic                    o_sat_evt
);

   localparam logic signed [LNS_W-1:0] SUM_MAX = LNS_W'(LOG_MAX);
   localparam logic signed [LNS_W-1:0] SUM_MIN = LNS_W'(LOG_MIN);

   // Priority selection: zero operand, overflow, underflow, exact minimum, in range.
   always_comb begin
      o_x       = LNS_ZERO;
      o_sat_evt = 1'b0;
      if (i_zero) begin
         o_x       = LNS_ZERO;
         o_sat_evt = 1'b0;
      end else if (i_sum > SUM_MAX) begin
         o_x       = '{sgn: i_sgn, log: 11'd1023};
         o_sat_evt = 1'b1;
      end else if (i_sum < SUM_MIN) begin
         o_x       = LNS_ZERO;
         o_sat_evt = 1'b1;
      end else if (i_sum == SUM_MIN) begin
         // -1024 is the zero code itself, so it collapses to zero without counting.
         o_x       = LNS_ZERO;
         o_sat_evt = 1'b0;
      end else begin
         o_x       = '{sgn: i_sgn, log: i_sum[LOG_W-1:0]};
         o_sat_evt = 1'b0;
      end
   end

endmodule : lns_sat_pack

// File: rtl/lns_mul_stage.sv
// -----------------------------------------------------------------------------
// lns_mul_stage
// Two-stage valid/ready LNS multiply front end. Forms a*b by log addition with
// saturation and forwards c aligned with the product.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand triple handshake (in_ready is combinational
//                         from out_ready)
//   a_in, b_in, c_in    : LNS operands; c is passed through unmodified
//   out_valid/out_ready : result handshake
//   x_out, y_out        : product and aligned addend, registered
//   sat_cnt, sat_clr    : saturating count of saturated products, and its clear
// -----------------------------------------------------------------------------
module lns_mul_stage
   import lns_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LNS_W-1:0] a_in,
   input  logic [LNS_W-1:0] b_in,
   input  logic [LNS_W-1:0] c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LNS_W-1:0] x_out,
   output logic [LNS_W-1:0] y_out,
   output logic [CNT_W-1:0] sat_cnt,
   input  logic             sat_clr
);

   lns_t w_a;
   lns_t w_b;
   logic w_s2_en;
   logic w_s1_en;
   logic signed [LNS_W-1:0] w_sum;
   lns_t w_x;
   logic w_sat_evt;

   // Stage 1 registers
   logic                    r_s1_valid;
   logic                    r_s1_sgn;
   logic signed [LNS_W-1:0] r_s1_sum;
   logic                    r_s1_zero;
   logic [LNS_W-1:0]        r_s1_c;

   // Output registers
   logic             r_out_valid;
   logic [LNS_W-1:0] r_x;
   logic [LNS_W-1:0] r_y;
   logic [CNT_W-1:0] r_sat_cnt;

   assign w_a = lns_t'(a_in);
   assign w_b = lns_t'(b_in);

   // An empty stage always loads, so bubbles collapse.
   assign w_s2_en  = !r_out_valid || out_ready;
   assign w_s1_en  = !r_s1_valid || w_s2_en;
   assign in_ready = w_s1_en;

   // Sign-extend each log field to 12 bits so the sum cannot wrap.
   assign w_sum = $signed({w_a.log[LOG_W-1], w_a.log}) + $signed({w_b.log[LOG_W-1], w_b.log});

   lns_sat_pack u_sat_pack (
      .i_sgn     (r_s1_sgn),
      .i_sum     (r_s1_sum),
      .i_zero    (r_s1_zero),
      .o_x       (w_x),
      .o_sat_evt (w_sat_evt)
   );

   // Stage 1: capture sign, log sum, zero flag and addend.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sgn   <= 1'b0;
         r_s1_sum   <= 12'sd0;
         r_s1_zero  <= 1'b0;
         r_s1_c     <= LNS_ZERO;
      end else if (w_s1_en) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_sgn  <= w_a.sgn ^ w_b.sgn;
            r_s1_sum  <= w_sum;
            r_s1_zero <= lns_is_zero(w_a) || lns_is_zero(w_b);
            r_s1_c    <= c_in;
         end
      end
   end

   // Stage 2: load packed product and aligned addend; hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_x         <= LNS_ZERO;
         r_y         <= LNS_ZERO;
      end else if (w_s2_en) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_x <= w_x;
            r_y <= r_s1_c;
         end
      end
   end

   // Saturation counter: counts only when a saturated result is actually loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat_cnt <= '0;
      end else if (sat_clr) begin
         r_sat_cnt <= '0;
      end else if (w_s2_en && r_s1_valid && w_sat_evt && (r_sat_cnt != {CNT_W{1'b1}})) begin
         r_sat_cnt <= r_sat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign out_valid = r_out_valid;
   assign x_out     = r_x;
   assign y_out     = r_y;
   assign sat_cnt   = r_sat_cnt;

endmodule : lns_mul_stage

// File: tb/tb_lns_mul_stage.sv
// -----------------------------------------------------------------------------
// tb_lns_mul_stage
// Directed stimulus with hand-computed expectations pushed into a scoreboard
// queue; an independent monitor pops and compares on every output transfer.
// -----------------------------------------------------------------------------
module tb_lns_mul_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] a_in;
   logic [11:0] b_in;
   logic [11:0] c_in;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] x_out;
   logic [11:0] y_out;
   logic [15:0] sat_cnt;
   logic        sat_clr;

   int errors = 0;
   int checks = 0;

   // entry = {x[11:0], y[11:0], sat_cnt[15:0]}
   logic [39:0] exp_q[$];

   lns_mul_stage #(.CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out),
      .y_out     (y_out),
      .sat_cnt   (sat_cnt),
      .sat_clr   (sat_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one triple; it transfers at the first posedge where in_ready is high.
   task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                       input logic [11:0] ex, input logic [11:0] ey, input logic [15:0] ecnt,
                       input bit push);
      int waited;
      waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      a_in = a;
      b_in = b;
      c_in = c;
      #1;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed 0 for a=%h b=%h", a, b);
      end else begin
         if (push) exp_q.push_back({ex, ey, ecnt});
         @(posedge clk);
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue_empty", 16'(exp_q.size()), 16'd0);
   endtask

   // Monitor: compare on every cycle that will complete an output transfer.
   initial begin
      logic [39:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got x=%h y=%h expected none", x_out, y_out);
            end else begin
               e = exp_q.pop_front();
               chk("x_out", {4'h0, x_out}, {4'h0, e[39:28]});
               chk("y_out", {4'h0, y_out}, {4'h0, e[27:16]});
               chk("sat_cnt", sat_cnt, e[15:0]);
            end
         end
      end
   end

   initial begin
      bit saw_ready_low;
      bit stable_ok;
      bit stale_seen;
      logic [11:0] hx;
      logic [11:0] hy;
      int n;

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      sat_clr = 1'b0;
      a_in = 12'h000;
      b_in = 12'h000;
      c_in = 12'h000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
      chk("rst_x_out", {4'h0, x_out}, 16'h0400);
      chk("rst_y_out", {4'h0, y_out}, 16'h0400);
      chk("rst_sat_cnt", sat_cnt, 16'd0);
      chk("rst_in_ready", {15'd0, in_ready}, 16'd1);

      // Products, signs, overflow, zero handling, upper boundary
      send(12'h080, 12'h080, 12'h123, 12'h100, 12'h123, 16'd0, 1'b1);
      send(12'h880, 12'h040, 12'h456, 12'h8C0, 12'h456, 16'd0, 1'b1);
      send(12'h880, 12'h880, 12'hC00, 12'h100, 12'hC00, 16'd0, 1'b1);
      send(12'h3FF, 12'h001, 12'h001, 12'h3FF, 12'h001, 16'd1, 1'b1);
      send(12'hBFF, 12'h3FF, 12'h002, 12'hBFF, 12'h002, 16'd2, 1'b1);
      send(12'h600, 12'h600, 12'h003, 12'h400, 12'h003, 16'd2, 1'b1);
      send(12'h600, 12'h5FF, 12'h004, 12'h400, 12'h004, 16'd3, 1'b1);
      send(12'hC00, 12'h880, 12'h005, 12'h400, 12'h005, 16'd3, 1'b1);
      send(12'h1FF, 12'h200, 12'h006, 12'h3FF, 12'h006, 16'd3, 1'b1);
      drain();

      // Backpressure: 5 streamed triples, output stalled after the first appears
      saw_ready_low = 1'b0;
      stable_ok = 1'b1;
      fork
         begin
            send(12'h001, 12'h001, 12'h0A1, 12'h002, 12'h0A1, 16'd3, 1'b1);
            send(12'h002, 12'h002, 12'h0A2, 12'h004, 12'h0A2, 16'd3, 1'b1);
            send(12'h803, 12'h001, 12'h0A3, 12'h804, 12'h0A3, 16'd3, 1'b1);
            send(12'h010, 12'h020, 12'h0A4, 12'h030, 12'h0A4, 16'd3, 1'b1);
            send(12'h7F0, 12'h010, 12'h0A5, 12'h000, 12'h0A5, 16'd3, 1'b1);
         end
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!out_valid && n < 20);
            out_ready = 1'b0;
            #1;
            hx = x_out;
            hy = y_out;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               #1;
               if (x_out !== hx || y_out !== hy) stable_ok = 1'b0;
               if (!in_ready) saw_ready_low = 1'b1;
            end
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      chk("stall_output_stable", {15'd0, stable_ok}, 16'd1);
      chk("stall_in_ready_dropped", {15'd0, saw_ready_low}, 16'd1);
      drain();

      // Reset with two triples in flight
      out_ready = 1'b0;
      send(12'h3FF, 12'h3FF, 12'h0B1, 12'h000, 12'h000, 16'd0, 1'b0);
      send(12'h001, 12'h001, 12'h0B2, 12'h000, 12'h000, 16'd0, 1'b0);
      @(negedge clk);
      #1;
      chk("inflight_sat_cnt", sat_cnt, 16'd4);
      chk("inflight_out_valid", {15'd0, out_valid}, 16'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("midrst_out_valid", {15'd0, out_valid}, 16'd0);
      chk("midrst_sat_cnt", sat_cnt, 16'd0);
      chk("midrst_x_out", {4'h0, x_out}, 16'h0400);
      rst = 1'b0;
      out_ready = 1'b1;
      stale_seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         #1;
         if (out_valid) stale_seen = 1'b1;
      end
      chk("no_stale_after_rst", {15'd0, stale_seen}, 16'd0);

      // Clear in the same cycle as a saturation event, then a plain event
      send(12'h3FF, 12'h001, 12'h007, 12'h3FF, 12'h007, 16'd0, 1'b1);
      @(negedge clk);
      sat_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sat_clr = 1'b0;
      send(12'h3FF, 12'h001, 12'h008, 12'h3FF, 12'h008, 16'd1, 1'b1);
      drain();

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_lns_mul_stage
